spi_reg_ctrl: RTL
=================

Name: spi_reg_ctrl

Overview:
- Sequences the byte-level SPI slave interface into register-bus transactions; sits between the SPI slave (rx/byte_received/tx) and the local register bank.
- Frame format, one frame per chip-select assertion:
  - byte0 = command: bit7 = 1 read / 0 write; bits6:0 = start address.
  - Following bytes: write data, or dummy bytes while read data shifts out.
- Addresses auto-increment per data byte.

Parameters:
- AUTO_INC, 1, 1 = address increments after each data byte (7-bit wrap, 0x7F -> 0x00); 0 = address fixed for the frame.
- ACK_TIMEOUT, 16, clk cycles to wait for reg_ack before aborting an access (range 2..255).
- STATUS_ID, 8'hA5, constant driven on tx_byte while the command byte shifts out.

Ports:
- clk  in  1  system clock, same domain as the SPI slave.
- reset  in  1  asynchronous, active-high.
- ssel_n  in  1  raw SPI chip select, active low; synchronised internally with 2 flops.
- rx_byte  in  8  received byte from the SPI slave; valid while rx_valid is high.
- rx_valid  in  1  one-cycle strobe, byte received.
- tx_byte  out  8  byte the SPI slave loads at the start of the next SPI byte.
- reg_addr  out  7  register address.
- reg_wdata  out  8  write data.
- reg_we  out  1  write request, held until reg_ack.
- reg_re  out  1  read request, held until reg_ack.
- reg_rdata  in  8  read data; valid when reg_ack and reg_re are both high.
- reg_ack  in  1  one-cycle access acknowledge.
- busy  out  1  high whenever state is not IDLE.
- ovr_err  out  1  sticky: rx_valid arrived while an access was pending.
- to_err  out  1  sticky: access timed out.
- clr_err  in  1  one-cycle pulse; clears both sticky errors.

Behaviour:
- Reset values:
  - tx_byte = STATUS_ID.
  - reg_addr, reg_wdata, reg_we, reg_re = 0.
  - busy, ovr_err, to_err = 0.
  - State = IDLE; timeout counter = 0.
- ssel_act = synchronised ~ssel_n, 2-flop latency.
- States: IDLE, CMD, WR_DATA, WR_ACC, RD_ACC, RD_DATA.
- IDLE:
  - tx_byte = STATUS_ID.
  - On ssel_act rising -> CMD.
- CMD:
  - On rx_valid: latch reg_addr = rx_byte[6:0].
  - If rx_byte[7] = 1: assert reg_re next cycle -> RD_ACC.
  - Else -> WR_DATA.
- WR_DATA:
  - On rx_valid: reg_wdata = rx_byte; assert reg_we next cycle -> WR_ACC.
- WR_ACC:
  - reg_we held until reg_ack.
  - On ack: deassert reg_we in the same edge; advance address per AUTO_INC; -> WR_DATA.
- RD_ACC:
  - reg_re held until reg_ack.
  - On ack: tx_byte = reg_rdata; deassert reg_re; -> RD_DATA.
  - Worst-case latency from rx_valid to tx_byte update = 1 + ack delay cycles.
- RD_DATA:
  - On rx_valid (dummy byte shifted in, read byte shifted out): advance address, assert reg_re (prefetch) -> RD_ACC.
- Timeout:
  - Counter runs while in WR_ACC/RD_ACC.
  - When it reaches ACK_TIMEOUT: drop reg_we/reg_re; set to_err.
  - Read timeout drives tx_byte = 8'hEE.
  - Next state: RD_DATA for reads, WR_DATA for writes.
- Overrun:
  - rx_valid during WR_ACC/RD_ACC sets ovr_err.
  - The byte is discarded; the pending access continues.
- End of frame (ssel_act falls):
  - From CMD/WR_DATA/RD_DATA -> IDLE next cycle.
  - From WR_ACC: the write completes (or times out) first, then IDLE.
  - From RD_ACC: reg_re is dropped immediately, any later ack is ignored, -> IDLE.
  - tx_byte returns to STATUS_ID in IDLE.
- Simultaneous clr_err and an error event in the same cycle: the error event wins, flag = 1.
- rx_valid in IDLE (SPI slave running without chip select) is ignored.
- reset mid-frame: all outputs return to reset values immediately (asynchronous); the frame is abandoned.
- reg_we and reg_re are never high in the same cycle.

Decomposition:
- Package spi_reg_pkg:
  - state encoding constants.
  - CMD_RD_BIT = 7.
  - STATUS_ID default.
  - RD_TIMEOUT_DATA = 8'hEE.
- Sub-module spi_sync2: 2-flop synchroniser, async reset to 1 (chip select inactive); used for ssel_n.
- All other logic lives in one FSM module.

Test Plan:
1. Write burst:
   - Stimulus: ssel low; rx 0x10, 0x11, 0x22; reg_ack 1 cycle after each request.
   - Expect: writes 0x10←0x11, 0x11←0x22; tx_byte = 0xA5 during cmd; no errors.
2. Read burst:
   - Stimulus: rx 0x85 then two dummies; bank returns 0x3C @5, 0x4D @6.
   - Expect: tx_byte = 0x3C after the first ack, 0x4D after the prefetch ack; reg_addr 5 then 6.
3. Wrap with AUTO_INC = 1:
   - Stimulus: write cmd 0x7F, data 0xAA, 0xBB.
   - Expect: writes @0x7F then @0x00.
4. Timeout with ACK_TIMEOUT = 16:
   - Stimulus: read cmd 0x81, reg_ack never asserted.
   - Expect: reg_re drops after 16 cycles; to_err = 1; tx_byte = 0xEE; clr_err pulse clears to_err.
5. Overrun:
   - Stimulus: reg_ack delayed 10 cycles; rx_valid arrives during WR_ACC.
   - Expect: ovr_err = 1; only the first data byte is written.
6. Abort:
   - Stimulus: ssel_n rises during RD_ACC; ack arrives 3 cycles later.
   - Expect: reg_re low within 3 cycles of the ssel_n edge; IDLE; ack ignored; tx_byte = 0xA5; asynchronous reset mid-write clears reg_we immediately.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types and constants for the SPI register controller
// Contents: FSM state encoding, command read bit, status/timeout byte values,
//           and the address-advance helper used by the sequencer.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_ACC  = 3'd3,
    ST_RD_ACC  = 3'd4,
    ST_RD_DATA = 3'd5
  } state_e;

  localparam int         CMD_RD_BIT      = 7;
  localparam logic [7:0] STATUS_ID_DEF   = 8'hA5;
  localparam logic [7:0] RD_TIMEOUT_DATA = 8'hEE;

  // 7-bit address space wraps naturally (0x7F -> 0x00).
  function automatic logic [6:0] next_addr(input logic [6:0] addr, input bit inc);
    return inc ? (addr + 7'd1) : addr;
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// rtl/spi_reg_ctrl_if.sv - SPI byte side and register bus side of the controller
// Signals: ssel_n/rx_byte/rx_valid/tx_byte (SPI slave), reg_addr/reg_wdata/
//          reg_we/reg_re/reg_rdata/reg_ack (register bank), busy/ovr_err/
//          to_err/clr_err (status). slave = controller view, master = environment.
interface spi_reg_ctrl_if;
  logic       ssel_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic       busy;
  logic       ovr_err;
  logic       to_err;
  logic       clr_err;

  modport slave (
    input  ssel_n, rx_byte, rx_valid, reg_rdata, reg_ack, clr_err,
    output tx_byte, reg_addr, reg_wdata, reg_we, reg_re, busy, ovr_err, to_err
  );

  modport master (
    output ssel_n, rx_byte, rx_valid, reg_rdata, reg_ack, clr_err,
    input  tx_byte, reg_addr, reg_wdata, reg_we, reg_re, busy, ovr_err, to_err
  );
endinterface

// File: rtl/spi_sync2.sv
// rtl/spi_sync2.sv - two-flop synchroniser that resets to 1 (chip select inactive)
// Ports: clk, reset (async, active-high), d_i (async input), q_o (synchronised output).
module spi_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - sequences SPI slave bytes into register bank reads/writes
// Ports: clk, reset (async, active-high), bus (spi_reg_ctrl_if.slave): SPI byte
//        stream in/out, register request/ack handshake, busy and sticky errors.
// Frame: byte0 = {rd, addr[6:0]}, then write data or dummy bytes for reads.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter bit         AUTO_INC    = 1'b1,
  parameter int         ACK_TIMEOUT = 16,
  parameter logic [7:0] STATUS_ID   = STATUS_ID_DEF
) (
  input  logic         clk,
  input  logic         reset,
  spi_reg_ctrl_if.slave bus
);
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_e     state_q;
  logic       ssel_n_s;
  logic       ssel_act;
  logic       ssel_act_q;
  logic [7:0] tmo_cnt_q;
  logic [7:0] tx_byte_q;
  logic [6:0] reg_addr_q;
  logic [7:0] reg_wdata_q;
  logic       reg_we_q;
  logic       reg_re_q;
  logic       ovr_err_q;
  logic       to_err_q;
  logic       tmo_hit;
  logic       ovr_set;
  logic       to_set;
  logic       ovr_err_d;
  logic       to_err_d;

  spi_sync2 u_ssel_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.ssel_n),
    .q_o   (ssel_n_s)
  );

  assign ssel_act = ~ssel_n_s;

  always_comb begin
    // Counter started at 0 with the request, so this edge is the ACK_TIMEOUT-th.
    tmo_hit   = (tmo_cnt_q == TMO_LAST);
    ovr_set   = bus.rx_valid && (state_q == ST_WR_ACC || state_q == ST_RD_ACC);
    // A read aborted by chip-select release is not a timeout.
    to_set    = tmo_hit && !bus.reg_ack &&
                (state_q == ST_WR_ACC || (state_q == ST_RD_ACC && ssel_act));
    // Set wins over a coincident clear.
    ovr_err_d = ovr_set | (ovr_err_q & ~bus.clr_err);
    to_err_d  = to_set  | (to_err_q  & ~bus.clr_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ssel_act_q  <= 1'b0;
      tmo_cnt_q   <= '0;
      tx_byte_q   <= STATUS_ID;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      ovr_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      ssel_act_q <= ssel_act;
      ovr_err_q  <= ovr_err_d;
      to_err_q   <= to_err_d;
      case (state_q)
        ST_IDLE: begin
          tx_byte_q <= STATUS_ID;
          if (ssel_act && !ssel_act_q) state_q <= ST_CMD;
        end
        ST_CMD: begin
          if (!ssel_act) begin
            state_q <= ST_IDLE;
          end else if (bus.rx_valid) begin
            reg_addr_q <= bus.rx_byte[6:0];
            tmo_cnt_q  <= '0;
            if (bus.rx_byte[CMD_RD_BIT]) begin
              reg_re_q <= 1'b1;
              state_q  <= ST_RD_ACC;
            end else begin
              state_q <= ST_WR_DATA;
            end
          end
        end
        ST_WR_DATA: begin
          if (!ssel_act) begin
            tx_byte_q <= STATUS_ID;
            state_q   <= ST_IDLE;
          end else if (bus.rx_valid) begin
            reg_wdata_q <= bus.rx_byte;
            reg_we_q    <= 1'b1;
            tmo_cnt_q   <= '0;
            state_q     <= ST_WR_ACC;
          end
        end
        ST_WR_ACC: begin
          // A started write always finishes (ack or timeout), even after frame end.
          if (bus.reg_ack || tmo_hit) begin
            reg_we_q <= 1'b0;
            if (bus.reg_ack) reg_addr_q <= next_addr(reg_addr_q, AUTO_INC);
            if (ssel_act) begin
              state_q <= ST_WR_DATA;
            end else begin
              tx_byte_q <= STATUS_ID;
              state_q   <= ST_IDLE;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        ST_RD_ACC: begin
          if (!ssel_act) begin
            reg_re_q  <= 1'b0;
            tx_byte_q <= STATUS_ID;
            state_q   <= ST_IDLE;
          end else if (bus.reg_ack) begin
            tx_byte_q <= bus.reg_rdata;
            reg_re_q  <= 1'b0;
            state_q   <= ST_RD_DATA;
          end else if (tmo_hit) begin
            tx_byte_q <= RD_TIMEOUT_DATA;
            reg_re_q  <= 1'b0;
            state_q   <= ST_RD_DATA;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        ST_RD_DATA: begin
          if (!ssel_act) begin
            tx_byte_q <= STATUS_ID;
            state_q   <= ST_IDLE;
          end else if (bus.rx_valid) begin
            // Byte just clocked out; prefetch the next address for the following byte.
            reg_addr_q <= next_addr(reg_addr_q, AUTO_INC);
            reg_re_q   <= 1'b1;
            tmo_cnt_q  <= '0;
            state_q    <= ST_RD_ACC;
          end
        end
        default: begin
          reg_we_q <= 1'b0;
          reg_re_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_byte   = tx_byte_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_re    = reg_re_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.ovr_err   = ovr_err_q;
  assign bus.to_err    = to_err_q;
endmodule
